int_div_iterative: RTL

//  Multi-cycle iterative integer divider, the inverse of the iterative multiplier in the

---
 rtl/int_div_pkg.sv | 15 +
 rtl/int_div_step.sv | 24 ++
 rtl/int_div_iterative.sv | 110 +++++++++++
 3 files changed

// File: rtl/int_div_pkg.sv
// Shared definitions for the iterative divider and the muldiv unit.
package int_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step-counter width for an n-bit divide; counts 0 .. n-1.
    function automatic int cnt_nbits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/int_div_step.sv
// One restoring-division step: shift in next dividend bit, trial-subtract divisor.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module int_div_step #(
    parameter int p_nbits = 32
) (
    input  logic [p_nbits-1:0] rem,
    input  logic [p_nbits-1:0] quot,
    input  logic [p_nbits-1:0] divisor,
    output logic [p_nbits-1:0] rem_nxt,
    output logic [p_nbits-1:0] quot_nxt
);

    logic [p_nbits:0] sh;
    logic [p_nbits:0] diff;

    assign sh   = {rem, quot[p_nbits-1]};
    assign diff = sh - {1'b0, divisor};

    // rem < divisor is invariant, so a restored remainder never needs the extra bit.
    assign rem_nxt  = diff[p_nbits] ? sh[p_nbits-1:0] : diff[p_nbits-1:0];
    assign quot_nxt = {quot[p_nbits-2:0], ~diff[p_nbits]};

endmodule

// File: rtl/int_div_iterative.sv
// Iterative restoring integer divider (signed/unsigned, RISC-V div-by-zero semantics).
// Latency: accept in cycle 0, result valid in cycle p_nbits+1; one op in flight.
// Backpressure: result held in DONE until ostream_rdy; istream_rdy low until then.
module int_div_iterative
    import int_div_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic               istream_signed,
    input  logic [p_nbits-1:0] istream_a,
    input  logic [p_nbits-1:0] istream_b,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [p_nbits-1:0] ostream_quot,
    output logic [p_nbits-1:0] ostream_rem
);

    localparam int CNT_NBITS = cnt_nbits(p_nbits);
    localparam logic [CNT_NBITS-1:0] CNT_LAST = CNT_NBITS'(p_nbits - 1);

    state_t               state;
    logic [CNT_NBITS-1:0] cnt;
    logic [p_nbits-1:0]   rem_q;
    logic [p_nbits-1:0]   quot_q;
    logic [p_nbits-1:0]   divisor_q;
    logic                 sign_q;
    logic                 sign_r;
    logic                 b_zero;

    logic [p_nbits-1:0]   rem_nxt;
    logic [p_nbits-1:0]   quot_nxt;
    logic [p_nbits-1:0]   a_mag;
    logic [p_nbits-1:0]   b_mag;
    logic                 a_neg;
    logic                 b_neg;

    assign a_neg = istream_signed & istream_a[p_nbits-1];
    assign b_neg = istream_signed & istream_b[p_nbits-1];
    // -2^(n-1) maps onto itself, which the unsigned datapath handles correctly.
    assign a_mag = a_neg ? -istream_a : istream_a;
    assign b_mag = b_neg ? -istream_b : istream_b;

    int_div_step #(.p_nbits(p_nbits)) u_step (
        .rem      (rem_q),
        .quot     (quot_q),
        .divisor  (divisor_q),
        .rem_nxt  (rem_nxt),
        .quot_nxt (quot_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            b_zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (istream_val) begin
                        state     <= CALC;
                        cnt       <= '0;
                        rem_q     <= '0;
                        quot_q    <= a_mag;
                        divisor_q <= b_mag;
                        sign_q    <= a_neg ^ b_neg;
                        sign_r    <= a_neg;
                        b_zero    <= (istream_b == '0);
                    end
                end
                CALC: begin
                    rem_q  <= rem_nxt;
                    quot_q <= quot_nxt;
                    cnt    <= cnt + CNT_NBITS'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ostream_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign istream_rdy = reset_n && (state == IDLE);
    assign ostream_val = (state == DONE);

    // Quotient sign is suppressed on divide-by-zero so the all-ones result survives.
    always_comb begin
        ostream_quot = '0;
        ostream_rem  = '0;
        if (state == DONE) begin
            ostream_quot = (sign_q && !b_zero) ? -quot_q : quot_q;
            ostream_rem  = sign_r ? -rem_q : rem_q;
        end
    end

endmodule
